// File: rtl/rr_packed_logb_gearbox.sv
// Gearbox packing the variable-length LSB-first logb stream into fixed OUT_WIDTH
// words, carrying residue bits across beats, with flush and statistics.
module rr_packed_logb_gearbox #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 512,
  parameter int CNT_WIDTH = 32,
  parameter int LEN_W     = $clog2(IN_WIDTH + 1),
  parameter int OLEN_W    = $clog2(OUT_WIDTH + 1),
  parameter int BUF_W     = OUT_WIDTH + IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [LEN_W-1:0]     in_len,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [OLEN_W-1:0]    out_len,
  input  logic                 out_ready,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] bits_in_cnt,
  output logic [CNT_WIDTH-1:0] words_out_cnt,
  output logic                 len_err
);

  localparam int FILL_W = $clog2(BUF_W + 1);

  if (IN_WIDTH < 1 || OUT_WIDTH < 1) begin : g_bad_params
    $error("rr_packed_logb_gearbox: IN_WIDTH and OUT_WIDTH must be >= 1");
  end

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(IN_WIDTH)) return LEN_W'(IN_WIDTH);
    return len;
  endfunction

  // Bits at or above n are forced to zero so the accumulator stays clean above fill.
  function automatic logic [IN_WIDTH-1:0] mask_data(input logic [IN_WIDTH-1:0] d,
                                                    input logic [LEN_W-1:0]    n);
    logic [IN_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (i < int'(n)) m[i] = d[i];
    end
    return m;
  endfunction

  logic [BUF_W-1:0]  acc_buf;
  logic [FILL_W-1:0] fill;
  logic              flush_pending;

  logic              pop;
  logic              push;
  logic [LEN_W-1:0]  elen;
  logic [FILL_W-1:0] fill_pop;
  logic [FILL_W-1:0] fill_nxt;
  logic [BUF_W-1:0]  buf_pop;
  logic [BUF_W-1:0]  buf_nxt;
  logic              pend_nxt;
  logic              done_nxt;

  assign in_ready  = !flush_pending && (fill <= FILL_W'(OUT_WIDTH));
  assign out_valid = (fill >= FILL_W'(OUT_WIDTH)) || (flush_pending && (fill != '0));
  assign out_len   = (fill >= FILL_W'(OUT_WIDTH)) ? OLEN_W'(OUT_WIDTH) : OLEN_W'(fill);
  assign out_data  = acc_buf[OUT_WIDTH-1:0];

  // Pop retires the head word first; the push then lands directly above the remaining residue.
  always_comb begin
    pop      = out_valid && out_ready;
    push     = in_valid && in_ready;
    elen     = push ? clamp_len(in_len) : '0;
    fill_pop = fill - (pop ? FILL_W'(out_len) : '0);
    buf_pop  = pop ? (acc_buf >> out_len) : acc_buf;
    buf_nxt  = buf_pop | (BUF_W'(mask_data(in_data, elen)) << fill_pop);
    fill_nxt = fill_pop + FILL_W'(elen);
    done_nxt = flush_pending && (fill_nxt == '0);
    pend_nxt = flush_pending;
    if (done_nxt) begin
      pend_nxt = 1'b0;
    end else if (flush_req && !flush_pending) begin
      pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_buf       <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
      bits_in_cnt   <= '0;
      words_out_cnt <= '0;
      len_err       <= 1'b0;
    end else begin
      acc_buf       <= buf_nxt;
      fill          <= fill_nxt;
      flush_pending <= pend_nxt;
      flush_done    <= done_nxt;
      bits_in_cnt   <= bits_in_cnt + CNT_WIDTH'(elen);
      if (pop) words_out_cnt <= words_out_cnt + 1'b1;
      if (push && (in_len > LEN_W'(IN_WIDTH))) len_err <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready)
      assert (in_len <= LEN_W'(IN_WIDTH))
        else $warning("in_len %0d exceeds IN_WIDTH, clamped", in_len);
  end

endmodule

// File: tb/tb_rr_packed_logb_gearbox.sv
// Bench for rr_packed_logb_gearbox: directed scenarios plus random traffic against
// a bit-queue reference model.
module tb_rr_packed_logb_gearbox;

  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int CW  = 32;
  localparam int LW  = 4;
  localparam int OLW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic [LW-1:0] in_len;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [OLW-1:0] out_len;
  logic          out_ready;
  logic          flush_req;
  logic          flush_done;
  logic [CW-1:0] bits_in_cnt;
  logic [CW-1:0] words_out_cnt;
  logic          len_err;

  rr_packed_logb_gearbox #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_len      (out_len),
    .out_ready    (out_ready),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .bits_in_cnt  (bits_in_cnt),
    .words_out_cnt(words_out_cnt),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  // Reference model: the un-emitted bitstream as a queue, oldest bit at the front.
  bit          q[$];
  logic        m_pend;
  logic        m_done;
  logic        m_lerr;
  logic [31:0] m_bits;
  logic [31:0] m_words;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_olen();
    return (q.size() < OW) ? q.size() : OW;
  endfunction

  function automatic logic m_ovalid();
    return (q.size() >= OW) || (m_pend && q.size() > 0);
  endfunction

  function automatic logic m_iready();
    return !m_pend && (q.size() <= OW);
  endfunction

  function automatic logic [OW-1:0] m_odata();
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < m_olen(); i++) w[i] = q[i];
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pend  = 1'b0;
    m_done  = 1'b0;
    m_lerr  = 1'b0;
    m_bits  = '0;
    m_words = '0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    bit pop;
    bit push;
    int olen;
    int elen;
    bit old_pend;
    pop      = m_ovalid() && out_ready;
    push     = in_valid && m_iready();
    olen     = m_olen();
    old_pend = m_pend;
    if (pop) begin
      repeat (olen) void'(q.pop_front());
      m_words++;
    end
    if (push) begin
      elen = (int'(in_len) > IW) ? IW : int'(in_len);
      if (int'(in_len) > IW) m_lerr = 1'b1;
      for (int i = 0; i < elen; i++) q.push_back(in_data[i]);
      m_bits += 32'(elen);
    end
    m_done = 1'b0;
    if (old_pend && q.size() == 0) begin
      m_pend = 1'b0;
      m_done = 1'b1;
    end
    if (flush_req && !old_pend) m_pend = 1'b1;
  endtask

  task automatic check_all();
    chk("in_ready",   32'(in_ready),   32'(m_iready()));
    chk("out_valid",  32'(out_valid),  32'(m_ovalid()));
    chk("out_len",    32'(out_len),    32'(m_olen()));
    chk("out_data",   32'(out_data),   32'(m_odata()));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("bits_in",    bits_in_cnt,     m_bits);
    chk("words_out",  words_out_cnt,   m_words);
    chk("len_err",    32'(len_err),    32'(m_lerr));
  endtask

  // Drive one cycle of inputs from a negedge, then check at the following negedge.
  task automatic beat(input logic v, input logic [IW-1:0] d, input logic [LW-1:0] l,
                      input logic ordy, input logic frq);
    in_valid  = v;
    in_data   = d;
    in_len    = l;
    out_ready = ordy;
    flush_req = frq;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [IW-1:0] b0;
    logic [IW-1:0] b1;
    logic [IW-1:0] b2;
    logic [OW-1:0] held;
    int            k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    out_ready = 1'b0;
    flush_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Two full bytes make one word.
    beat(1'b1, 8'hAB, 4'd8, 1'b1, 1'b0);
    beat(1'b1, 8'hCD, 4'd8, 1'b1, 1'b0);
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_word",  32'(out_data),  32'h0000CDAB);
    chk("s1_len",   32'(out_len),   32'd16);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("s1_words", words_out_cnt, 32'd1);
    chk("s1_bits",  bits_in_cnt,   32'd16);

    // Odd lengths, with garbage above in_len that must be masked.
    beat(1'b1, 8'hFF, 4'd5, 1'b1, 1'b0);
    beat(1'b1, 8'h80, 4'd7, 1'b1, 1'b0);
    beat(1'b1, 8'hFF, 4'd6, 1'b1, 1'b0);
    chk("s2_word", 32'(out_data), 32'h0000F01F);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("s2_resid_len", 32'(out_len), 32'd2);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
    chk("s2_flush_ready", 32'(in_ready),  32'd0);
    chk("s2_flush_word",  32'(out_data),  32'h00000003);
    chk("s2_flush_len",   32'(out_len),   32'd2);
    chk("s2_flush_valid", 32'(out_valid), 32'd1);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("s2_flush_done",  32'(flush_done), 32'd1);
    chk("s2_ready_after", 32'(in_ready),   32'd1);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("s2_done_pulse",  32'(flush_done), 32'd0);

    // Backpressure: fill past one word, data must hold, then drain in order.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    k  = 0;
    while (in_ready && k < 10) begin
      beat(1'b1, (k == 0) ? b0 : (k == 1) ? b1 : b2, 4'd8, 1'b0, 1'b0);
      k++;
    end
    chk("bp_pushes", 32'(k), 32'd3);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    held = out_data;
    chk("bp_word0", 32'(held), 32'({b1, b0}));
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 8'h55, 4'd8, 1'b0, 1'b0);
      chk("bp_hold", 32'(out_data), 32'(held));
    end
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
    chk("bp_tail", 32'(out_data), 32'(b2));
    chk("bp_tail_len", 32'(out_len), 32'd8);
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    chk("bp_done", 32'(flush_done), 32'd1);

    // Zero-length beats interleaved must not disturb the stream.
    beat(1'b1, 8'h12, 4'd8, 1'b1, 1'b0);
    beat(1'b1, 8'hEE, 4'd0, 1'b1, 1'b0);
    beat(1'b1, 8'h34, 4'd8, 1'b1, 1'b0);
    chk("len0_word", 32'(out_data), 32'h00003412);
    beat(1'b1, 8'h77, 4'd0, 1'b1, 1'b0);
    chk("len0_bits",  bits_in_cnt,   32'd74);
    chk("len0_words", words_out_cnt, 32'd6);

    // Over-length beat is clamped and latches len_err.
    beat(1'b1, 8'hC3, 4'd9, 1'b0, 1'b0);
    chk("ovr_err",  32'(len_err),     32'd1);
    chk("ovr_bits", bits_in_cnt,      32'd82);
    beat(1'b1, 8'h5A, 4'd8, 1'b0, 1'b0);
    chk("ovr_word", 32'(out_data), 32'h00005AC3);
    chk("ovr_sticky", 32'(len_err), 32'd1);

    // Asynchronous reset mid-stream.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid),  32'd0);
    chk("arst_ready", 32'(in_ready),   32'd1);
    chk("arst_len",   32'(out_len),    32'd0);
    chk("arst_bits",  bits_in_cnt,     32'd0);
    chk("arst_words", words_out_cnt,   32'd0);
    chk("arst_err",   32'(len_err),    32'd0);
    chk("arst_done",  32'(flush_done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      beat(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 8)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end

    // Final drain.
    beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
    k = 0;
    while ((q.size() != 0 || m_pend || m_done) && k < 60) begin
      beat(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
      k++;
    end
    if (k >= 60) chk("drain_timeout", 32'd1, 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
